regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU result) and B (load data).
- Uses valid/ready handshakes with round-robin priority and one registered output stage that drives the register file's regwrite, write_reg and write_data inputs.
- Keeps a pending-write scoreboard, one bit per register, so the issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, width of the write data.
- ADDR_W, 5, width of a register index.
- NREG, 32, number of registers; must equal 2**ADDR_W.
- ZERO_RO, 1, when 1, writes and issues targeting register 0 are discarded.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's write is granted this cycle.
- a_reg  in  ADDR_W  A's destination register.
- a_data  in  DATA_W  A's write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's write is granted this cycle.
- b_reg  in  ADDR_W  B's destination register.
- b_data  in  DATA_W  B's write data.
- issue_valid  in  1  an instruction with destination issue_reg is issuing.
- issue_reg  in  ADDR_W  destination register of the issuing instruction.
- flush  in  1  synchronous pipeline flush.
- pending  out  NREG  scoreboard; bit r set means a write to r is outstanding.
- rf_regwrite  out  1  write enable to the register file.
- rf_write_reg  out  ADDR_W  register-file write address.
- rf_write_data  out  DATA_W  register-file write data.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - rf_regwrite=0, rf_write_reg=0, rf_write_data=0.
  - pending=0.
  - last_grant=B, so A wins the first tie.
- Reset is asserted independently of clk and takes effect immediately.
- Any in-flight write is lost on reset.
- Arbiter states: LAST_A and LAST_B, a 1-bit flop.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not granted last, then toggle.
  - Neither valid: no grant; the state holds.
- a_ready and b_ready are combinational from the valid inputs and the state.
  - At most one is high.
  - ready never depends on the other requester's data.
- Handshake: a transfer occurs when valid && ready on the same rising edge.
  - An ungranted requester must hold valid, reg and data stable until it is granted.
- Write latency is 1 cycle.
  - A grant in cycle N gives rf_regwrite=1 with the captured reg and data during cycle N+1.
  - The register file commits that write on the edge ending cycle N+1.
  - The output stage reloads every cycle, so there is no backpressure from the register file.
- Without a grant, rf_regwrite goes to 0 next cycle. rf_write_reg and rf_write_data hold their last values.
- Zero register (ZERO_RO=1):
  - A granted write to register 0 completes its handshake, but rf_regwrite stays 0.
  - An issue to register 0 does not set pending[0].
  - pending[0] is always 0.
- Scoreboard updates each edge:
  - Set: issue_valid sets pending[issue_reg].
  - Clear: rf_regwrite clears pending[rf_write_reg].
  - Set and clear of the same register on the same edge: set wins, because a new producer is now outstanding.
  - Set and clear of different registers on the same edge: both apply.
- A write to a register whose pending bit is 0 is still performed. The bit stays 0.
- flush (synchronous), on the edge where it is sampled high:
  - pending clears to 0; any same-edge issue is ignored.
  - No grant is made that cycle: a_ready=b_ready=0 combinationally while flush=1.
  - A write already in the output stage still completes. It is older than the flush.
  - The arbiter state holds.
- Back-to-back grants from one requester are allowed, at one write per cycle.
- Sustained throughput is one write per cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - the constants DATA_W, ADDR_W, NREG, ZERO_REG=0;
  - the typedef reg_idx_t [ADDR_W-1:0];
  - the typedef reg_data_t [DATA_W-1:0];
  - the enum arb_last_t {LAST_A, LAST_B}.
- One sub-module: rf_scoreboard, which owns the pending vector and the set/clear/flush priority logic.
- The arbiter and the output stage stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release with no valids → rf_regwrite=0 and pending=0; the first tie (a_reg=1, a_data=20; b_reg=2, b_data=40) grants A.
- Tie sequence: both valid for 4 cycles → grants alternate A,B,A,B. rf_regwrite=1 in every cycle from 1 after the first grant; rf_write_reg follows 1,2,1,2 with data 20,40,20,40.
- Single requester: B valid alone with b_reg=3, b_data=30 for 3 cycles → b_ready=1 every cycle and three writes of 30 to register 3; a_ready stays 0.
- Scoreboard: issue reg 5 at cycle 0 → pending[5]=1 from cycle 1. A writes reg 5 at cycle 3 → pending[5] clears after the commit edge. Issue reg 5 on the same edge as the commit → pending[5] stays 1.
- Zero register: A writes reg 0, data 0xdead → a_ready=1 and rf_regwrite stays 0. Issue reg 0 → pending[0]=0.
- Flush and mid-operation reset:
  - flush=1 with pending=0x0000_0024 and both requesters valid → no ready that cycle, and pending=0 after the edge.
  - rst_n dropped mid-write → rf_regwrite=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, index/data types and arbiter state encoding for the
// register-file writeback path.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREG     = 32;
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } arb_last_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared when
// the register file commits the write.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG_P   = regfile_pkg::NREG,
  parameter int ADDR_W_P = regfile_pkg::ADDR_W,
  parameter int ZERO_RO  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                set_valid,
  input  logic [ADDR_W_P-1:0] set_reg,
  input  logic                clr_valid,
  input  logic [ADDR_W_P-1:0] clr_reg,
  output logic [NREG_P-1:0]   pending
);

  logic [NREG_P-1:0] pending_next;

  // Set is applied after clear so a new producer on the committing register wins.
  always_comb begin
    pending_next = pending;
    if (flush) begin
      pending_next = '0;
    end else begin
      if (clr_valid) pending_next[clr_reg] = 1'b0;
      if (set_valid) pending_next[set_reg] = 1'b1;
    end
    if (ZERO_RO != 0) pending_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter between ALU (A) and load (B) writeback, with a single
// registered stage driving the register-file write port and a RAW scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int NREG    = regfile_pkg::NREG,
  parameter int ZERO_RO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              flush,
  output logic [NREG-1:0]   pending,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data
);

  arb_last_t         last, last_next;
  logic              grant;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              sel_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= LAST_B;
    else        last <= last_next;
  end

  // A wins when alone or when B was served last; flush blocks every grant.
  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    last_next = last;
    if (!flush) begin
      if (a_valid && (!b_valid || last == LAST_B)) begin
        a_ready   = 1'b1;
        last_next = LAST_A;
      end else if (b_valid) begin
        b_ready   = 1'b1;
        last_next = LAST_B;
      end
    end
  end

  assign grant    = a_ready | b_ready;
  assign sel_reg  = a_ready ? a_reg  : b_reg;
  assign sel_data = a_ready ? a_data : b_data;
  assign sel_zero = (ZERO_RO != 0) && (sel_reg == ADDR_W'(ZERO_REG));

  // Reloads every cycle; address and data only move on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_regwrite   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      rf_regwrite <= grant && !sel_zero;
      if (grant) begin
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
      end
    end
  end

  rf_scoreboard #(
    .NREG_P   (NREG),
    .ADDR_W_P (ADDR_W),
    .ZERO_RO  (ZERO_RO)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .set_valid (issue_valid),
    .set_reg   (issue_reg),
    .clr_valid (rf_regwrite),
    .clr_reg   (rf_write_reg),
    .pending   (pending)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed checks of the writeback arbiter against a
// transaction-level model of grants, register-file writes and pending bits.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_reg, b_reg, issue_reg, rf_write_reg;
  logic [31:0] a_data, b_data, rf_write_data, pending;
  logic        issue_valid, flush, rf_regwrite;

  int checks = 0;
  int errors = 0;

  bit          m_last_was_a;
  bit          m_rw;
  bit [4:0]    m_wreg;
  bit [31:0]   m_wdata;
  bit          m_addr_known;
  bit [31:0]   m_pend;
  bit          m_ga, m_gb;

  bit          cur_av, cur_bv;
  bit [4:0]    cur_ar, cur_br;
  bit [31:0]   cur_ad, cur_bd;

  regfile_write_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_reg         (a_reg),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_reg         (b_reg),
    .b_data        (b_data),
    .issue_valid   (issue_valid),
    .issue_reg     (issue_reg),
    .flush         (flush),
    .pending       (pending),
    .rf_regwrite   (rf_regwrite),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_last_was_a = 1'b0;
    m_rw         = 1'b0;
    m_wreg       = '0;
    m_wdata      = '0;
    m_addr_known = 1'b1;
    m_pend       = '0;
    m_ga         = 1'b0;
    m_gb         = 1'b0;
  endtask

  task automatic checkState();
    checkOutput("rf_regwrite", rf_regwrite, m_rw);
    if (m_addr_known) begin
      checkOutput("rf_write_reg", rf_write_reg, m_wreg);
      checkOutput("rf_write_data", rf_write_data, m_wdata);
    end
    checkOutput("pending", pending, m_pend);
  endtask

  // One cycle: drive just after a falling edge, check readies, step the
  // model across the rising edge, check registered outputs on the next fall.
  task automatic applyStimulus(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                               input bit bv, input bit [4:0] br, input bit [31:0] bd,
                               input bit iv, input bit [4:0] ir, input bit fl);
    bit [4:0]  g_reg;
    bit [31:0] g_data;
    cur_av = av; cur_ar = ar; cur_ad = ad;
    cur_bv = bv; cur_br = br; cur_bd = bd;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    issue_valid = iv; issue_reg = ir; flush = fl;
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (!fl) begin
      if (av && bv) begin
        if (m_last_was_a) m_gb = 1'b1;
        else              m_ga = 1'b1;
      end else if (av) m_ga = 1'b1;
      else if (bv)     m_gb = 1'b1;
    end
    #1;
    checkOutput("a_ready", a_ready, m_ga);
    checkOutput("b_ready", b_ready, m_gb);
    @(posedge clk);
    if (fl) m_pend = '0;
    else begin
      if (m_rw) m_pend[m_wreg] = 1'b0;
      if (iv && ir != 0) m_pend[ir] = 1'b1;
    end
    if (m_ga || m_gb) begin
      g_reg        = m_ga ? ar : br;
      g_data       = m_ga ? ad : bd;
      m_last_was_a = m_ga;
      m_rw         = (g_reg != 0);
      m_addr_known = (g_reg != 0);
      m_wreg       = g_reg;
      m_wdata      = g_data;
    end else begin
      m_rw = 1'b0;
    end
    @(negedge clk);
    checkState();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    issue_valid = 0; issue_reg = 0; flush = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkState();
    rst_n = 1'b1;
    idle();
    checkOutput("reset_regwrite", rf_regwrite, 1'b0);
    checkOutput("reset_pending", pending, 32'h0);

    // Tie: A first, then alternate
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 5'd1, 32'd20, 1, 5'd2, 32'd40, 0, 0, 0);
      checkOutput("tie_reg", rf_write_reg, (i % 2 == 0) ? 5'd1 : 5'd2);
      checkOutput("tie_data", rf_write_data, (i % 2 == 0) ? 32'd20 : 32'd40);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 5'd3, 32'd30, 0, 0, 0);
      checkOutput("single_b_write", {rf_regwrite, rf_write_reg, rf_write_data}, {1'b1, 5'd3, 32'd30});
    end
    idle();

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
    checkOutput("sb_set5", pending[5], 1'b1);
    idle();
    idle();
    applyStimulus(1, 5'd5, 32'd55, 0, 0, 0, 0, 0, 0);
    idle();
    checkOutput("sb_clr5", pending[5], 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
    applyStimulus(1, 5'd5, 32'd66, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
    checkOutput("sb_set_wins", pending[5], 1'b1);

    applyStimulus(1, 5'd0, 32'hdead, 0, 0, 0, 0, 0, 0);
    checkOutput("zero_no_write", rf_regwrite, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, 0);
    checkOutput("zero_pending", pending[0], 1'b0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
    checkOutput("pre_flush_pending", pending, 32'h0000_0024);
    applyStimulus(1, 5'd7, 32'd70, 1, 5'd8, 32'd80, 1, 5'd9, 1);
    checkOutput("flush_pending", pending, 32'h0);

    applyStimulus(1, 5'd7, 32'd70, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_reset_write", rf_regwrite, 1'b1);
    a_valid = 0; b_valid = 0; issue_valid = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_regwrite", rf_regwrite, 1'b0);
    modelReset();
    cur_av = 0; cur_bv = 0;
    @(negedge clk);
    checkState();
    rst_n = 1'b1;

    // Random traffic; an ungranted requester keeps its request stable
    for (int i = 0; i < 400; i++) begin
      bit av, bv, iv, fl;
      bit [4:0] ar, br, ir;
      bit [31:0] ad, bd;
      if (cur_av && !m_ga) begin
        av = 1; ar = cur_ar; ad = cur_ad;
      end else begin
        av = bit'($urandom_range(0, 1)); ar = 5'($urandom); ad = $urandom;
      end
      if (cur_bv && !m_gb) begin
        bv = 1; br = cur_br; bd = cur_bd;
      end else begin
        bv = bit'($urandom_range(0, 1)); br = 5'($urandom); bd = $urandom;
      end
      iv = bit'($urandom_range(0, 1));
      ir = 5'($urandom);
      fl = ($urandom_range(0, 15) == 0);
      applyStimulus(av, ar, ad, bv, br, bd, iv, ir, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
